// File: rtl/req_arb4_pkg.sv
// Shared constants and state encoding for the 4-port round-robin arbiter.
package req_arb4_pkg;

   localparam int unsigned NUM_PORTS = 4;
   localparam int unsigned PTR_W     = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/Mux4_RTL.sv
// Four-input, p_nbits-wide message multiplexer.
module Mux4_RTL #(
   parameter int unsigned p_nbits = 32
) (
   input  logic [p_nbits-1:0] in0,
   input  logic [p_nbits-1:0] in1,
   input  logic [p_nbits-1:0] in2,
   input  logic [p_nbits-1:0] in3,
   input  logic [1:0]         sel,
   output logic [p_nbits-1:0] out
);

   always_comb begin
      out = in0;
      case (sel)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         2'd3:    out = in3;
         default: out = in0;
      endcase
   end

endmodule

// File: rtl/req_arb4.sv
// Round-robin arbiter of four val/rdy requesters into a one-entry output buffer.
module req_arb4
   import req_arb4_pkg::*;
#(
   parameter int unsigned p_nbits = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in0_val,
   input  logic               in1_val,
   input  logic               in2_val,
   input  logic               in3_val,
   output logic               in0_rdy,
   output logic               in1_rdy,
   output logic               in2_rdy,
   output logic               in3_rdy,
   input  logic [p_nbits-1:0] in0_msg,
   input  logic [p_nbits-1:0] in1_msg,
   input  logic [p_nbits-1:0] in2_msg,
   input  logic [p_nbits-1:0] in3_msg,
   output logic               out_val,
   input  logic               out_rdy,
   output logic [p_nbits-1:0] out_msg,
   output logic [1:0]         out_src
);

   state_e               r_state;
   state_e               w_state_next;
   logic [PTR_W-1:0]     r_ptr;
   logic [PTR_W-1:0]     r_src;
   logic [p_nbits-1:0]   r_msg;
   logic [PTR_W-1:0]     w_win;
   logic                 w_any;
   logic                 w_accept_en;
   logic                 w_accept;
   logic [NUM_PORTS-1:0] w_val;
   logic [NUM_PORTS-1:0] w_rdy;
   logic [p_nbits-1:0]   w_win_msg;

   assign w_val = {in3_val, in2_val, in1_val, in0_val};

   // Scan from the highest offset down so the closest requester to ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (w_val[r_ptr + PTR_W'(k)]) begin
            w_any = 1'b1;
            w_win = r_ptr + PTR_W'(k);
         end
      end
   end

   Mux4_RTL #(.p_nbits(p_nbits)) u_win_mux (
      .in0 (in0_msg),
      .in1 (in1_msg),
      .in2 (in2_msg),
      .in3 (in3_msg),
      .sel (w_win),
      .out (w_win_msg)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_next;
   end

   // Next state and grants; a draining buffer can accept a new message in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_rdy        = '0;
      w_accept_en  = (r_state == ST_EMPTY) || out_rdy;
      w_accept     = w_accept_en && w_any && !rst;
      if (w_accept) w_rdy[w_win] = 1'b1;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
         ST_FULL:  if (out_rdy && !w_accept) w_state_next = ST_EMPTY;
         default:  w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_src <= '0;
         r_msg <= '0;
      end else if (w_accept) begin
         r_ptr <= w_win + PTR_W'(1);
         r_src <= w_win;
         r_msg <= w_win_msg;
      end
   end

   // Outputs are forced idle for the whole reset window, including its first cycle.
   assign out_val = (r_state == ST_FULL) && !rst;
   assign out_msg = rst ? '0 : r_msg;
   assign out_src = rst ? '0 : r_src;
   assign in0_rdy = w_rdy[0];
   assign in1_rdy = w_rdy[1];
   assign in2_rdy = w_rdy[2];
   assign in3_rdy = w_rdy[3];

endmodule

// File: tb/tb_req_arb4.sv
// Scoreboard bench for req_arb4: model predicts grants and queues expected outputs.
module tb_req_arb4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  val;
   logic [31:0] msg [4];
   logic        out_rdy;
   logic        in0_rdy, in1_rdy, in2_rdy, in3_rdy;
   logic        out_val;
   logic [31:0] out_msg;
   logic [1:0]  out_src;

   typedef struct {
      int          src;
      logic [31:0] msg;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   ptr_m  = 0;
   bit   pop_pending = 1'b0;

   always #5 clk = ~clk;

   req_arb4 #(.p_nbits(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .in0_val (val[0]),
      .in1_val (val[1]),
      .in2_val (val[2]),
      .in3_val (val[3]),
      .in0_rdy (in0_rdy),
      .in1_rdy (in1_rdy),
      .in2_rdy (in2_rdy),
      .in3_rdy (in3_rdy),
      .in0_msg (msg[0]),
      .in1_msg (msg[1]),
      .in2_msg (msg[2]),
      .in3_msg (msg[3]),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_msg (out_msg),
      .out_src (out_src)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare the presented output against the oldest expected entry.
   always @(negedge clk) begin
      pop_pending = 1'b0;
      if (!rst) begin
         chk("out_val", 64'(out_val), 64'(sb.size() != 0));
         if (out_val && sb.size() > 0) begin
            chk("out_src", 64'(out_src), 64'(sb[0].src));
            chk("out_msg", 64'(out_msg), 64'(sb[0].msg));
            pop_pending = out_rdy;
         end
      end
   end

   always @(posedge clk) begin
      if (pop_pending && sb.size() > 0) void'(sb.pop_front());
   end

   // One cycle: predict and check grants, then record any accepted message.
   task automatic step();
      bit          en;
      int          win;
      logic [3:0]  exp_rdy;
      logic [31:0] wmsg;
      @(negedge clk);
      en  = (sb.size() == 0) || out_rdy;
      win = -1;
      for (int k = 0; k < 4; k++) begin
         if (win < 0 && val[(ptr_m + k) % 4]) win = (ptr_m + k) % 4;
      end
      exp_rdy = (en && win >= 0) ? 4'(1 << win) : 4'd0;
      chk("in_rdy", 64'({in3_rdy, in2_rdy, in1_rdy, in0_rdy}), 64'(exp_rdy));
      wmsg = (win >= 0) ? msg[win] : 32'd0;
      @(posedge clk);
      if (en && win >= 0) begin
         sb.push_back('{src: win, msg: wmsg});
         ptr_m = (win + 1) % 4;
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_rdy", 64'({in3_rdy, in2_rdy, in1_rdy, in0_rdy}), 64'd0);
         chk("rst_out_val", 64'(out_val), 64'd0);
         chk("rst_out_msg", 64'(out_msg), 64'd0);
         chk("rst_out_src", 64'(out_src), 64'd0);
         @(posedge clk);
      end
      sb.delete();
      ptr_m = 0;
      #1 rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      val     = 4'd0;
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) msg[i] = 32'd0;
      #1;
      do_reset(2);

      // Idle: nothing valid, consumer ready.
      repeat (5) step();

      // All four valid, continuous drain: rotating sources 0,1,2,3,0...
      for (int i = 0; i < 4; i++) msg[i] = 32'hA0 + 32'(i);
      val = 4'hF;
      repeat (6) step();
      val = 4'd0;
      repeat (2) step();

      // Single requester with stalled consumer.
      msg[2]  = 32'h55;
      val     = 4'b0100;
      out_rdy = 1'b0;
      step();
      repeat (3) step();
      val     = 4'd0;
      out_rdy = 1'b1;
      repeat (2) step();

      // Replace a draining buffer in the same cycle.
      msg[1] = 32'h11;
      val    = 4'b0010;
      step();
      msg[3] = 32'h77;
      val    = 4'b1000;
      step();
      val    = 4'd0;
      repeat (2) step();

      // Pointer at 2 after in1 wins; then in3 beats in1, then in1 gets its turn.
      val = 4'b0010;
      step();
      val = 4'b1010;
      repeat (2) step();
      val = 4'd0;
      repeat (2) step();

      // Reset while full discards the buffer and restarts arbitration at 0.
      msg[0]  = 32'hC0;
      val     = 4'b0001;
      out_rdy = 1'b0;
      repeat (2) step();
      val     = 4'd0;
      do_reset(1);
      msg[0]  = 32'hD0;
      msg[1]  = 32'hD1;
      val     = 4'b0011;
      out_rdy = 1'b1;
      repeat (3) step();
      val = 4'd0;
      repeat (2) step();

      // Random traffic with random back-pressure.
      for (int c = 0; c < 400; c++) begin
         val = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) msg[i] = $urandom;
         out_rdy = ($urandom_range(0, 3) != 0);
         step();
      end
      val     = 4'd0;
      out_rdy = 1'b1;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
